fir_coef_loader: RTL

- Initiator side of the FIR coefficient-programming interface: drives write_address / write_value / load, plus read_address during verify, into fir_transpose.
- Accepts coefficients from an upstream valid/ready stream and writes them into taps 0..NUM_TAPS-1 in order.
- Holds the filter halted while programming and releases it when finished.
- Optionally reads the bank back and checksums it before release.

---
 rtl/fir_coef_loader_if.sv | 32 +++
 rtl/fir_coef_loader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader_if.sv
// Coefficient-loader bus: upstream stream, FIR write/read port and status.
// master = loader side, slave = upstream/FIR/controller side.
interface fir_coef_loader_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [DATA_W-1:0] coef_data;
    logic              coef_valid;
    logic              coef_ready;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_value;
    logic              load;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] read_value;
    logic              fir_hlt;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, coef_data, coef_valid, read_value,
        output coef_ready, write_address, write_value, load, read_address,
               fir_hlt, busy, done, error
    );

    modport slave (
        output start, coef_data, coef_valid, read_value,
        input  coef_ready, write_address, write_value, load, read_address,
               fir_hlt, busy, done, error
    );
endinterface

// File: rtl/fir_coef_loader.sv
// Programs NUM_TAPS FIR coefficients from a valid/ready stream, holding the filter halted meanwhile.
// Define FIR_COEF_READBACK_VERIFY_EN to read the bank back and checksum it before release.
module fir_coef_loader #(
    parameter int DATA_W   = 12,
    parameter int ADDR_W   = 8,
    parameter int NUM_TAPS = 16
) (
    input logic              clk,
    input logic              rst_n,
    fir_coef_loader_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TAPS - 1);

`ifdef FIR_COEF_READBACK_VERIFY_EN
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, VERIFY, DONE, FAIL} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DONE} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              coef_ready_r;
    logic [ADDR_W-1:0] write_address_r;
    logic [DATA_W-1:0] write_value_r;
    logic              load_r;
    logic              fir_hlt_r;
    logic              busy_r;
    logic              done_r;
    logic              beat;

    assign beat = bus.coef_valid && coef_ready_r;

`ifdef FIR_COEF_READBACK_VERIFY_EN
    localparam int SUM_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0] read_address_r;
    logic              error_r;
    logic              rd_issue;
    logic              sample_pend;
    logic [ADDR_W-1:0] sample_addr;
    logic [SUM_W-1:0]  wr_sum;
    logic [SUM_W-1:0]  rd_sum;
    logic [SUM_W-1:0]  wr_term;
    logic [SUM_W-1:0]  rd_term;
    logic [SUM_W-1:0]  rd_sum_next;

    // Address is folded into each term so a tap written to the wrong slot changes the sum.
    always_comb begin
        wr_term     = {{ADDR_W{1'b0}}, bus.coef_data} ^ {{DATA_W{1'b0}}, idx};
        rd_term     = {{ADDR_W{1'b0}}, bus.read_value} ^ {{DATA_W{1'b0}}, sample_addr};
        rd_sum_next = rd_sum + rd_term;
    end

    assign bus.read_address = read_address_r;
    assign bus.error        = error_r;
`else
    logic [DATA_W-1:0] unused_read_value;

    assign unused_read_value = bus.read_value;
    assign bus.read_address  = '0;
    assign bus.error         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= '0;
            coef_ready_r    <= 1'b0;
            write_address_r <= '0;
            write_value_r   <= '0;
            load_r          <= 1'b0;
            fir_hlt_r       <= 1'b1;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
`ifdef FIR_COEF_READBACK_VERIFY_EN
            read_address_r  <= '0;
            error_r         <= 1'b0;
            rd_issue        <= 1'b0;
            sample_pend     <= 1'b0;
            sample_addr     <= '0;
            wr_sum          <= '0;
            rd_sum          <= '0;
`endif
        end else begin
            load_r <= 1'b0;
            case (state)
                LOAD: begin
                    if (beat) begin
                        load_r          <= 1'b1;
                        write_address_r <= idx;
                        write_value_r   <= bus.coef_data;
`ifdef FIR_COEF_READBACK_VERIFY_EN
                        wr_sum          <= wr_sum + wr_term;
`endif
                        if (idx == LAST) begin
                            coef_ready_r <= 1'b0;
                            state        <= DRAIN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                // One cycle for the final write strobe to land before halt can drop.
                DRAIN: begin
`ifdef FIR_COEF_READBACK_VERIFY_EN
                    read_address_r <= '0;
                    rd_issue       <= 1'b1;
                    sample_pend    <= 1'b0;
                    state          <= VERIFY;
`else
                    busy_r    <= 1'b0;
                    done_r    <= 1'b1;
                    fir_hlt_r <= 1'b0;
                    state     <= DONE;
`endif
                end

`ifdef FIR_COEF_READBACK_VERIFY_EN
                // read_value lags read_address by one cycle, so the sample address is pipelined.
                VERIFY: begin
                    sample_pend <= rd_issue;
                    sample_addr <= read_address_r;
                    if (rd_issue) begin
                        if (read_address_r == LAST) begin
                            rd_issue <= 1'b0;
                        end else begin
                            read_address_r <= read_address_r + 1'b1;
                        end
                    end
                    if (sample_pend) begin
                        rd_sum <= rd_sum_next;
                        if (sample_addr == LAST) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            if (rd_sum_next == wr_sum) begin
                                fir_hlt_r <= 1'b0;
                                state     <= DONE;
                            end else begin
                                error_r <= 1'b1;
                                state   <= FAIL;
                            end
                        end
                    end
                end
`endif

                default: begin
                    if (bus.start) begin
                        state        <= LOAD;
                        idx          <= '0;
                        coef_ready_r <= 1'b1;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        fir_hlt_r    <= 1'b1;
`ifdef FIR_COEF_READBACK_VERIFY_EN
                        error_r      <= 1'b0;
                        rd_issue     <= 1'b0;
                        sample_pend  <= 1'b0;
                        wr_sum       <= '0;
                        rd_sum       <= '0;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.coef_ready    = coef_ready_r;
    assign bus.write_address = write_address_r;
    assign bus.write_value   = write_value_r;
    assign bus.load          = load_r;
    assign bus.fir_hlt       = fir_hlt_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
endmodule
